// File: rtl/icmp_echo_buf_pkg.sv
// Shared definitions for the ICMP echo payload buffer: FSM states and
// drop-counter saturation.
package icmp_echo_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_LOAD,
    ST_START,
    ST_SEND
  } state_t;

  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/icmp_echo_ram.sv
// Simple dual-port payload RAM: one synchronous write port and one
// synchronous read port with 1-cycle latency.
module icmp_echo_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // The read register doubles as the tx_data output, so it holds between
  // reads and clears on reset; the array itself is never reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/icmp_echo_buf.sv
// Buffers one received ICMP echo payload as 32-bit words and replays it
// byte-exact as the echo-reply payload; drops and counts busy/bad packets.
module icmp_echo_buf
  import icmp_echo_buf_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        rec_en,
  input  logic [31:0] rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] tx_data,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int          DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  state_t            state_reg;
  logic [ADDR_W:0]   wr_cnt_reg;
  logic [ADDR_W:0]   rd_ptr_reg;
  logic [ADDR_W:0]   words_reg;
  logic [15:0]       byte_num_reg;
  logic              ovf_reg;

  logic              rx_state;
  logic              full;
  logic              ovf_now;
  logic [16:0]       words_calc;
  logic              drop_pkt;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic              send_read;

  assign rx_state = (state_reg == ST_IDLE) || (state_reg == ST_RECV);
  // wr_cnt carries one extra bit so a completely filled buffer is distinct
  // from an empty one.
  assign full       = wr_cnt_reg[ADDR_W];
  assign ovf_now    = ovf_reg || (rec_en && full);
  assign words_calc = ({1'b0, rec_byte_num} + 17'd3) >> 2;
  assign drop_pkt   = ovf_now || (words_calc > 17'(DEPTH)) || (rec_byte_num == 16'd0);

  assign ram_we      = rx_state && rec_en && !full;
  assign send_read   = (state_reg == ST_SEND) && tx_req && !tx_done && (rd_ptr_reg < words_reg);
  assign ram_re      = (state_reg == ST_LOAD) || send_read;
  assign ram_rd_addr = (state_reg == ST_LOAD) ? '0 : rd_ptr_reg[ADDR_W-1:0];

  icmp_echo_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (gmii_rx_clk),
    .rst     (rst),
    .we      (ram_we),
    .wr_addr (wr_cnt_reg[ADDR_W-1:0]),
    .wr_data (rec_data),
    .re      (ram_re),
    .rd_addr (ram_rd_addr),
    .rd_data (tx_data)
  );

  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wr_cnt_reg   <= '0;
      rd_ptr_reg   <= '0;
      words_reg    <= '0;
      byte_num_reg <= '0;
      ovf_reg      <= 1'b0;
      tx_start_en  <= 1'b0;
      tx_byte_num  <= '0;
      busy         <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      tx_start_en <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_RECV: begin
          if (rec_en) begin
            if (full) ovf_reg    <= 1'b1;
            else      wr_cnt_reg <= wr_cnt_reg + PTR_ONE;
            state_reg <= ST_RECV;
          end
          // A word arriving with rec_pkt_done is written above; only the
          // pointer bookkeeping is overridden here.
          if (rec_pkt_done) begin
            byte_num_reg <= rec_byte_num;
            words_reg    <= words_calc[ADDR_W:0];
            wr_cnt_reg   <= '0;
            ovf_reg      <= 1'b0;
            if (drop_pkt) begin
              drop_cnt  <= sat_inc(drop_cnt);
              state_reg <= ST_IDLE;
            end else begin
              busy      <= 1'b1;
              state_reg <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (rec_pkt_done) drop_cnt <= sat_inc(drop_cnt);
          rd_ptr_reg  <= PTR_ONE;
          tx_start_en <= 1'b1;
          tx_byte_num <= byte_num_reg;
          state_reg   <= ST_START;
        end
        ST_START: begin
          if (rec_pkt_done) drop_cnt <= sat_inc(drop_cnt);
          state_reg <= ST_SEND;
        end
        ST_SEND: begin
          if (rec_pkt_done) drop_cnt <= sat_inc(drop_cnt);
          if (tx_done) begin
            rd_ptr_reg <= '0;
            wr_cnt_reg <= '0;
            busy       <= 1'b0;
            state_reg  <= ST_IDLE;
          end else if (send_read) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icmp_echo_buf.sv
// Scoreboard bench for icmp_echo_buf: accepted payload words are queued as
// they are fed and popped as the reply side produces them.
module tb_icmp_echo_buf;

  logic        gmii_rx_clk = 1'b0;
  logic        rst = 1'b1;
  logic        rec_en = 1'b0;
  logic [31:0] rec_data = '0;
  logic        rec_pkt_done = 1'b0;
  logic [15:0] rec_byte_num = '0;
  logic        tx_req = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;
  logic        busy;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_word;

  icmp_echo_buf #(.ADDR_W(9)) dut (
    .gmii_rx_clk  (gmii_rx_clk),
    .rst          (rst),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num),
    .tx_req       (tx_req),
    .tx_done      (tx_done),
    .tx_start_en  (tx_start_en),
    .tx_byte_num  (tx_byte_num),
    .tx_data      (tx_data),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  always #4 gmii_rx_clk = ~gmii_rx_clk;

  task automatic tick;
    @(posedge gmii_rx_clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    @(negedge gmii_rx_clk);
    rst = 1'b0;
    exp_q.delete();
    tick();
  endtask

  // Feed n words starting at seed (step 0x04040404), then the packet end.
  task automatic feed(input int n, input logic [31:0] seed, input bit keep,
                      input bit done_with_last, input logic [15:0] nbytes);
    logic [31:0] w;
    w = seed;
    for (int i = 0; i < n; i++) begin
      rec_en = 1'b1;
      rec_data = w;
      if (keep) exp_q.push_back(w);
      if (done_with_last && i == n - 1) begin
        rec_pkt_done = 1'b1;
        rec_byte_num = nbytes;
      end
      tick();
      w = w + 32'h04040404;
    end
    rec_en = 1'b0;
    if (!(done_with_last && n > 0)) begin
      rec_pkt_done = 1'b1;
      rec_byte_num = nbytes;
      tick();
    end
    rec_pkt_done = 1'b0;
    rec_byte_num = '0;
  endtask

  task automatic wait_start(input string tag);
    int lat;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!tx_start_en && lat < 20);
    total++;
    if (!tx_start_en) begin
      bad++;
      $display("FAIL %s_start_timeout: tx_start_en=%0b required=1", tag, tx_start_en);
    end else if (lat + 1 != 2) begin
      bad++;
      $display("FAIL %s_latency: got=%0d required=2", tag, lat + 1);
    end
  endtask

  task automatic check_no_start(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx_start_en) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL %s_no_start: tx_start_en pulses=%0d required=0", tag, seen);
    end
  endtask

  task automatic check_word(input string tag);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_underflow: scoreboard empty, tx_data=%h", tag, tx_data);
    end else begin
      e = exp_q.pop_front();
      last_word = e;
      if (tx_data !== e) begin
        bad++;
        $display("FAIL %s_data: tx_data=%h required=%h", tag, tx_data, e);
      end
    end
  endtask

  task automatic check_drop(input string tag, input logic [7:0] e);
    total++;
    if (drop_cnt !== e) begin
      bad++;
      $display("FAIL %s_drop_cnt: drop_cnt=%0d required=%0d", tag, drop_cnt, e);
    end
  endtask

  // Called with tx_start_en high: checks header word, requests the rest
  // back to back, one extra request past the end, then tx_done.
  task automatic drain(input string tag, input int n, input logic [15:0] nbytes);
    total++;
    if (tx_byte_num !== nbytes) begin
      bad++;
      $display("FAIL %s_byte_num: tx_byte_num=%0d required=%0d", tag, tx_byte_num, nbytes);
    end
    check_word(tag);
    tick();
    tx_req = 1'b1;
    for (int k = 1; k < n; k++) begin
      tick();
      check_word(tag);
    end
    tick();
    tx_req = 1'b0;
    total++;
    if (tx_data !== last_word) begin
      bad++;
      $display("FAIL %s_hold: tx_data=%h required=%h", tag, tx_data, last_word);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_end: busy=%0b left=%0d required busy=0 left=0", tag, busy, exp_q.size());
    end
    $display("txn %s: %0d words, %0d bytes", tag, n, nbytes);
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if (tx_start_en !== 1'b0 || tx_byte_num !== 16'd0 || tx_data !== 32'd0 ||
        busy !== 1'b0 || drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: start=%0b bytes=%0d data=%h busy=%0b drop=%0d required all 0",
               tx_start_en, tx_byte_num, tx_data, busy, drop_cnt);
    end
    $display("txn reset: outputs idle");
  endtask

  task automatic test_basic;
    feed(5, 32'h01020304, 1'b1, 1'b0, 16'd20);
    wait_start("basic");
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy: busy=%0b required=1", busy);
    end
    drain("basic", 5, 16'd20);
  endtask

  task automatic test_same_cycle;
    feed(7, 32'h31323334, 1'b1, 1'b1, 16'd28);
    wait_start("same_cycle");
    drain("same_cycle", 7, 16'd28);
  endtask

  task automatic test_overflow;
    do_reset();
    feed(513, 32'h50000000, 1'b0, 1'b0, 16'd2052);
    check_no_start("overflow", 10);
    check_drop("overflow", 8'd1);
    feed(2, 32'h61626364, 1'b1, 1'b0, 16'd8);
    wait_start("after_overflow");
    drain("after_overflow", 2, 16'd8);
  endtask

  task automatic test_busy_drop;
    feed(4, 32'h70717273, 1'b1, 1'b0, 16'd14);
    wait_start("busy_drop");
    check_word("busy_drop");
    tick();
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    check_word("busy_drop");
    feed(3, 32'hDEAD0000, 1'b0, 1'b0, 16'd12);
    check_drop("busy_drop", 8'd2);
    tx_req = 1'b1;
    tick();
    check_word("busy_drop");
    tick();
    check_word("busy_drop");
    tx_req = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_no_start("busy_drop_after", 10);
    $display("txn busy_drop: reply intact, drop_cnt=%0d", drop_cnt);
  endtask

  task automatic test_zero_len;
    do_reset();
    feed(0, 32'h0, 1'b0, 1'b0, 16'd0);
    check_no_start("zero_len", 8);
    check_drop("zero_len", 8'd1);
    for (int i = 1; i < 300; i++) begin
      rec_pkt_done = 1'b1;
      tick();
      rec_pkt_done = 1'b0;
      tick();
    end
    check_drop("saturate", 8'd255);
    $display("txn saturate: 300 drops, drop_cnt=%0d", drop_cnt);
  endtask

  task automatic test_rst_mid_send;
    feed(4, 32'h90919293, 1'b1, 1'b0, 16'd16);
    wait_start("rst_mid");
    tick();
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (tx_start_en !== 1'b0 || tx_byte_num !== 16'd0 || tx_data !== 32'd0 ||
        busy !== 1'b0 || drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs: start=%0b bytes=%0d data=%h busy=%0b drop=%0d required all 0",
               tx_start_en, tx_byte_num, tx_data, busy, drop_cnt);
    end
    exp_q.delete();
    @(negedge gmii_rx_clk);
    rst = 1'b0;
    tick();
    total++;
    if (tx_start_en !== 1'b0) begin
      bad++;
      $display("FAIL rst_release_start: tx_start_en=%0b required=0", tx_start_en);
    end
    feed(1, 32'hAABBCCDD, 1'b1, 1'b0, 16'd4);
    wait_start("after_rst");
    drain("after_rst", 1, 16'd4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_overflow();
    test_busy_drop();
    test_zero_len();
    test_rst_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
